uart_receiver: RTL and testbench
================================

# uart_receiver

UART serial receiver (8N1, LSB first) with a parameterised baud divider. It sits between the external RX pin and the downstream byte consumer (e.g. the SHA-256 message loader). It oversamples the line with the system clock, validates the start and stop bits, and emits each byte with a one-cycle valid strobe. It also mirrors the last good byte onto an LED bus for board-level debug.

## Interface
- CLKS_PER_BIT, default 868: system clocks per UART bit (100 MHz / 115200). Legal range ≥ 4.
- CLK  in  1  system clock; all logic on the rising edge.
- RST_N  in  1  asynchronous, active-low reset.
- Rx_Serial_in  in  1  asynchronous serial line; idles high.
- Rx_DV_out  out  1  one-cycle pulse when a valid byte is received.
- Rx_Byte_out  out  8  last valid received byte; held between frames.
- LED_out  out  8  copy of the last valid byte, for board LEDs.

## Operation
- Rx_Serial_in passes through a 2-flop synchronizer, rx_s, before any use. Both flops reset to 1.
- Bit counter clk_cnt is $clog2(CLKS_PER_BIT) bits wide; bit_idx is 3 bits.
- FSM states: IDLE, START, DATA, STOP, CLEANUP.
  - IDLE: clk_cnt=0, bit_idx=0. If rx_s==0, go to START.
  - START: count up. When clk_cnt==(CLKS_PER_BIT-1)/2 (mid start bit): if rx_s==0, clear clk_cnt and go to DATA; else treat as a glitch and go to IDLE.
  - DATA: when clk_cnt==CLKS_PER_BIT-1, store rx_s into shift[bit_idx] and clear clk_cnt. If bit_idx==7, clear bit_idx and go to STOP; else increment bit_idx.
  - STOP: when clk_cnt==CLKS_PER_BIT-1 (mid stop bit), check rx_s. If 1, load Rx_Byte_out and LED_out from shift and pulse Rx_DV_out. If 0 (framing error), discard the byte: no strobe, outputs unchanged. Then go to CLEANUP.
  - CLEANUP: one cycle, then IDLE.
- Rx_DV_out is high for exactly one CLK cycle per good frame and is never high in two consecutive cycles.
- Rx_Byte_out and LED_out change only in the cycle Rx_DV_out rises.
- No parity, no FIFO, no overrun flag.

## Timing
- Reset state: IDLE. All counters 0; Rx_DV_out=0, Rx_Byte_out=0x00, LED_out=0x00; synchronizer flops=1.
- Reset takes effect immediately, including mid-frame: any partial byte is dropped and no strobe is issued.
- Latency from the input falling edge of the start bit to the Rx_DV_out pulse: 2 (sync) + 1 (IDLE detect) + (CLKS_PER_BIT-1)/2 + 1 + 9·CLKS_PER_BIT cycles, ±1. For 868 that is ≈ 8249 cycles.
- Rx_Byte_out and LED_out are valid in the same cycle as Rx_DV_out and stay stable until the next good frame.
- Back-to-back frames with zero idle time between them must be received. The FSM is back in IDLE about half a bit before the stop bit ends.
- A low pulse shorter than about half a bit period on an idle line produces no strobe.

## Structure
- Shared package uart_pkg holds:
  - the state enum (IDLE/START/DATA/STOP/CLEANUP);
  - DEFAULT_CLKS_PER_BIT = 868.
- Sub-module sync_2ff: 2-flop synchronizer with reset value 1. It is reusable by the UART transmitter and other CDC inputs.
- Everything else lives in one always block plus its output registers.

## Test plan
- Send 'a','b','c' (0x61, 0x62, 0x63) at CLKS_PER_BIT=868, with one idle bit after each stop bit. Expect exactly 3 Rx_DV_out pulses carrying 0x61, 0x62, 0x63 in order, and LED_out=0x63 at the end.
- Send 0x00 then 0xFF back-to-back with no idle gap (CLKS_PER_BIT=16). Expect two strobes, with 0x00 then 0xFF.
- Send frame 0xA5 with the stop bit driven 0. Expect no strobe and Rx_Byte_out unchanged. Then send a valid 0x3C. Expect a strobe with 0x3C.
- Drive a low glitch of CLKS_PER_BIT/4 cycles on an idle line. Expect no strobe and the FSM back in IDLE.
- Assert RST_N low mid-way through a 0x55 frame, release it, then send 0x81. Expect outputs 0x00 during reset, no strobe for 0x55, and one strobe with 0x81.
- Check every strobe with an assertion: Rx_DV_out is always exactly one cycle wide.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM state encoding and default baud divider.
package uart_pkg;

  localparam int DEFAULT_CLKS_PER_BIT = 868;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    CLEANUP
  } state_t;

endpackage

// File: rtl/uart_receiver_if.sv
// Byte-side bundle of the UART receiver: serial line in, byte strobe and mirrors out.
interface uart_receiver_if;

  logic       Rx_Serial_in;
  logic       Rx_DV_out;
  logic [7:0] Rx_Byte_out;
  logic [7:0] LED_out;

  // master: the receiver itself; slave: whatever drives the pin and consumes bytes
  modport master (
    input  Rx_Serial_in,
    output Rx_DV_out,
    output Rx_Byte_out,
    output LED_out
  );

  modport slave (
    output Rx_Serial_in,
    input  Rx_DV_out,
    input  Rx_Byte_out,
    input  LED_out
  );

endinterface

// File: rtl/uart_receiver_sync_2ff.sv
// Two-flop synchronizer for asynchronous inputs; resets to 1 so an idle UART line reads idle.
module sync_2ff (
  input  logic CLK,
  input  logic RST_N,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_receiver.sv
// 8N1 UART receiver: samples mid-bit, validates start/stop bits, strobes each good byte.
module uart_receiver
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic CLK,
  input  logic RST_N,
  uart_receiver_if.master rx_if
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_CNT = CW'((CLKS_PER_BIT - 1) / 2);
  localparam logic [CW-1:0] LAST_CNT = CW'(CLKS_PER_BIT - 1);

  logic          rx_s;
  state_t        state;
  logic [CW-1:0] clk_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shift;
  logic          rx_dv;
  logic [7:0]    rx_byte;
  logic [7:0]    led;

  sync_2ff u_sync (
    .CLK   (CLK),
    .RST_N (RST_N),
    .d     (rx_if.Rx_Serial_in),
    .q     (rx_s)
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state   <= IDLE;
      clk_cnt <= '0;
      bit_idx <= '0;
      shift   <= '0;
      rx_dv   <= 1'b0;
      rx_byte <= '0;
      led     <= '0;
    end else begin
      rx_dv <= 1'b0;
      unique case (state)
        IDLE: begin
          clk_cnt <= '0;
          bit_idx <= '0;
          if (!rx_s) state <= START;
        end
        START: begin
          if (clk_cnt == HALF_CNT) begin
            // still low at mid start bit: real frame; otherwise a glitch
            clk_cnt <= '0;
            state   <= rx_s ? IDLE : DATA;
          end else begin
            clk_cnt <= clk_cnt + CW'(1);
          end
        end
        DATA: begin
          if (clk_cnt == LAST_CNT) begin
            clk_cnt        <= '0;
            shift[bit_idx] <= rx_s;
            if (bit_idx == 3'd7) begin
              bit_idx <= '0;
              state   <= STOP;
            end else begin
              bit_idx <= bit_idx + 3'd1;
            end
          end else begin
            clk_cnt <= clk_cnt + CW'(1);
          end
        end
        STOP: begin
          if (clk_cnt == LAST_CNT) begin
            clk_cnt <= '0;
            // a low stop bit is a framing error: drop the byte silently
            if (rx_s) begin
              rx_byte <= shift;
              led     <= shift;
              rx_dv   <= 1'b1;
            end
            state <= CLEANUP;
          end else begin
            clk_cnt <= clk_cnt + CW'(1);
          end
        end
        CLEANUP: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign rx_if.Rx_DV_out   = rx_dv;
  assign rx_if.Rx_Byte_out = rx_byte;
  assign rx_if.LED_out     = led;

endmodule

// File: tb/tb_uart_receiver.sv
// Scoreboard bench for uart_receiver: one instance at the default divider, one at 16 clocks/bit.
module tb_uart_receiver;
  import uart_pkg::*;

  localparam int CA = 868;
  localparam int CB = 16;

  logic CLK;
  logic rst_a, rst_b;

  int unsigned errors = 0;
  int unsigned checks = 0;
  int unsigned a_strobes = 0;

  logic [7:0] qa[$];
  logic [7:0] qb[$];
  logic [7:0] last_good_b;
  logic       prev_dv_a, prev_dv_b;

  uart_receiver_if a_if ();
  uart_receiver_if b_if ();

  uart_receiver #(.CLKS_PER_BIT(CA)) dut_a (.CLK(CLK), .RST_N(rst_a), .rx_if(a_if));
  uart_receiver #(.CLKS_PER_BIT(CB)) dut_b (.CLK(CLK), .RST_N(rst_b), .rx_if(b_if));

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Line driver: each call holds one level for one bit period of the selected instance.
  task automatic drive_bit(input bit sel, input logic v);
    if (sel) b_if.Rx_Serial_in = v;
    else     a_if.Rx_Serial_in = v;
    repeat (sel ? CB : CA) @(posedge CLK);
    #1;
  endtask

  // Reference model: a frame yields its data byte iff its stop bit is 1.
  task automatic send_frame(input bit sel, input logic [7:0] d, input bit stop_bit,
                            input int unsigned idle_bits);
    if (stop_bit) begin
      if (sel) begin qb.push_back(d); last_good_b = d; end
      else qa.push_back(d);
    end
    drive_bit(sel, 1'b0);
    for (int unsigned i = 0; i < 8; i++) drive_bit(sel, d[i]);
    drive_bit(sel, stop_bit);
    for (int unsigned i = 0; i < idle_bits; i++) drive_bit(sel, 1'b1);
  endtask

  task automatic drain(input bit sel, input string name);
    int unsigned n;
    n = 0;
    while ((sel ? qb.size() : qa.size()) != 0 && n < 20 * CA) begin
      @(posedge CLK);
      n++;
    end
    #1;
    check(name, sel ? qb.size() : qa.size(), 0);
  endtask

  // Monitors: pop the expected byte on every strobe.
  always @(negedge CLK) begin
    if (rst_a) begin
      if (a_if.Rx_DV_out) begin
        a_strobes++;
        check("a_dv_width", {31'd0, prev_dv_a}, 0);
        if (qa.size() == 0) check("a_unexpected_strobe", {24'd0, a_if.Rx_Byte_out}, 32'hFFFF_FFFF);
        else begin
          logic [7:0] e;
          e = qa.pop_front();
          check("a_byte", {24'd0, a_if.Rx_Byte_out}, {24'd0, e});
          check("a_led",  {24'd0, a_if.LED_out},     {24'd0, e});
        end
      end
      prev_dv_a <= a_if.Rx_DV_out;
    end else prev_dv_a <= 1'b0;
  end

  always @(negedge CLK) begin
    if (rst_b) begin
      if (b_if.Rx_DV_out) begin
        check("b_dv_width", {31'd0, prev_dv_b}, 0);
        if (qb.size() == 0) check("b_unexpected_strobe", {24'd0, b_if.Rx_Byte_out}, 32'hFFFF_FFFF);
        else begin
          logic [7:0] e;
          e = qb.pop_front();
          check("b_byte", {24'd0, b_if.Rx_Byte_out}, {24'd0, e});
          check("b_led",  {24'd0, b_if.LED_out},     {24'd0, e});
        end
      end
      prev_dv_b <= b_if.Rx_DV_out;
    end else prev_dv_b <= 1'b0;
  end

  a_dv_pulse: assert property (@(posedge CLK) disable iff (!rst_a)
                               a_if.Rx_DV_out |=> !a_if.Rx_DV_out);
  b_dv_pulse: assert property (@(posedge CLK) disable iff (!rst_b)
                               b_if.Rx_DV_out |=> !b_if.Rx_DV_out);

  initial begin
    #(70000 * 10);
    $display("FAIL watchdog: simulation exceeded time limit");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1);
  end

  initial begin
    rst_a = 1'b0;
    rst_b = 1'b0;
    last_good_b = 8'h00;
    a_if.Rx_Serial_in = 1'b1;
    b_if.Rx_Serial_in = 1'b1;
    repeat (5) @(posedge CLK);
    #1;
    check("a_reset_byte", {24'd0, a_if.Rx_Byte_out}, 0);
    check("a_reset_led",  {24'd0, a_if.LED_out}, 0);
    check("a_reset_dv",   {31'd0, a_if.Rx_DV_out}, 0);
    check("b_reset_byte", {24'd0, b_if.Rx_Byte_out}, 0);
    check("b_reset_dv",   {31'd0, b_if.Rx_DV_out}, 0);
    rst_a = 1'b1;
    rst_b = 1'b1;
    repeat (3) @(posedge CLK);
    #1;

    fork
      begin
        send_frame(1'b0, 8'h61, 1'b1, 1);
        send_frame(1'b0, 8'h62, 1'b1, 1);
        send_frame(1'b0, 8'h63, 1'b1, 1);
        drain(1'b0, "a_drain_abc");
        check("a_strobe_count", a_strobes, 3);
        check("a_final_led", {24'd0, a_if.LED_out}, 32'h63);
      end
      begin
        // back-to-back, no idle gap
        send_frame(1'b1, 8'h00, 1'b1, 0);
        send_frame(1'b1, 8'hFF, 1'b1, 2);
        drain(1'b1, "b_drain_b2b");

        // framing error then a good frame
        send_frame(1'b1, 8'hA5, 1'b0, 2);
        repeat (2 * CB) @(posedge CLK);
        #1;
        check("b_framing_hold", {24'd0, b_if.Rx_Byte_out}, {24'd0, last_good_b});
        check("b_framing_led",  {24'd0, b_if.LED_out},     {24'd0, last_good_b});
        send_frame(1'b1, 8'h3C, 1'b1, 1);
        drain(1'b1, "b_drain_3c");

        // short glitch on an idle line
        b_if.Rx_Serial_in = 1'b0;
        repeat (CB / 4) @(posedge CLK);
        #1;
        b_if.Rx_Serial_in = 1'b1;
        repeat (2 * CB) @(posedge CLK);
        #1;
        check("b_glitch_idle", {29'd0, dut_b.state}, {29'd0, IDLE});
        check("b_glitch_hold", {24'd0, b_if.Rx_Byte_out}, 32'h3C);

        // reset in the middle of a 0x55 frame
        drive_bit(1'b1, 1'b0);
        for (int unsigned i = 0; i < 4; i++) drive_bit(1'b1, i[0] ? 1'b0 : 1'b1);
        rst_b = 1'b0;
        #1;
        check("b_midreset_byte", {24'd0, b_if.Rx_Byte_out}, 0);
        check("b_midreset_led",  {24'd0, b_if.LED_out}, 0);
        check("b_midreset_dv",   {31'd0, b_if.Rx_DV_out}, 0);
        b_if.Rx_Serial_in = 1'b1;
        last_good_b = 8'h00;
        repeat (3 * CB) @(posedge CLK);
        #1;
        rst_b = 1'b1;
        repeat (2 * CB) @(posedge CLK);
        #1;
        check("b_postreset_byte", {24'd0, b_if.Rx_Byte_out}, 0);
        send_frame(1'b1, 8'h81, 1'b1, 1);
        drain(1'b1, "b_drain_81");

        // randomized frames; a bad stop bit is always followed by idle time
        for (int unsigned k = 0; k < 12; k++) begin
          logic [7:0] d;
          bit sb;
          int unsigned gap;
          d   = 8'($urandom);
          sb  = ($urandom_range(7) != 0);
          gap = sb ? $urandom_range(2) : 1 + $urandom_range(1);
          send_frame(1'b1, d, sb, gap);
        end
        drive_bit(1'b1, 1'b1);
        drain(1'b1, "b_drain_random");
        check("b_random_last", {24'd0, b_if.LED_out}, {24'd0, last_good_b});
      end
    join

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
